// File: rtl/modulo_entrada.sv
// Operator input block: waits for a processor request, debounces the confirm key
// and captures the synchronised switch bank as a 32-bit word with a one-cycle ready.
module modulo_entrada #(
  parameter int SW_W            = 16,
  parameter int SIGN_EXT        = 0,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flag,
  input  logic [SW_W-1:0] switches,
  input  logic            confirm,
  output logic [31:0]     data_out,
  output logic            ready,
  output logic            waiting
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WAIT_PRESS, WAIT_RELEASE} state_e;

  logic            key_s1_q, key_s1_d, key_s2_q, key_s2_d;
  logic [SW_W-1:0] sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            key_db_q, key_db_d, key_db_prev_q, key_db_prev_d;
  state_e          state_q, state_d;
  logic [31:0]     data_q, data_d;
  logic            ready_q, ready_d, waiting_q, waiting_d;
  logic            press;
  logic [31:0]     sw_ext;

  generate
    if (SW_W >= 32) begin : g_full
      assign sw_ext = sw_s2_q[31:0];
    end else if (SIGN_EXT != 0) begin : g_sext
      assign sw_ext = {{(32-SW_W){sw_s2_q[SW_W-1]}}, sw_s2_q};
    end else begin : g_zext
      assign sw_ext = {{(32-SW_W){1'b0}}, sw_s2_q};
    end
  endgenerate

  // Press is a registered edge of key_db, so capture lands one edge after key_db falls.
  assign press = key_db_prev_q & ~key_db_q;

  always_comb begin
    key_s1_d      = confirm;
    key_s2_d      = key_s1_q;
    sw_s1_d       = switches;
    sw_s2_d       = sw_s1_q;
    key_db_prev_d = key_db_q;

    cnt_d    = '0;
    key_db_d = key_db_q;
    if (key_s2_q != key_db_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) key_db_d = key_s2_q;
      else                                      cnt_d    = cnt_q + 1'b1;
    end

    state_d = state_q;
    data_d  = data_q;
    ready_d = 1'b0;
    case (state_q)
      IDLE:         if (flag) state_d = WAIT_PRESS;
      // A falling flag wins over a coincident press.
      WAIT_PRESS: begin
        if (!flag) state_d = IDLE;
        else if (press) begin
          data_d  = sw_ext;
          ready_d = 1'b1;
          state_d = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: if (key_db_q) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
    waiting_d = (state_d == WAIT_PRESS);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_s1_q      <= 1'b1;
      key_s2_q      <= 1'b1;
      sw_s1_q       <= '0;
      sw_s2_q       <= '0;
      cnt_q         <= '0;
      key_db_q      <= 1'b1;
      key_db_prev_q <= 1'b1;
      state_q       <= IDLE;
      data_q        <= '0;
      ready_q       <= 1'b0;
      waiting_q     <= 1'b0;
    end else begin
      key_s1_q      <= key_s1_d;
      key_s2_q      <= key_s2_d;
      sw_s1_q       <= sw_s1_d;
      sw_s2_q       <= sw_s2_d;
      cnt_q         <= cnt_d;
      key_db_q      <= key_db_d;
      key_db_prev_q <= key_db_prev_d;
      state_q       <= state_d;
      data_q        <= data_d;
      ready_q       <= ready_d;
      waiting_q     <= waiting_d;
    end
  end

  assign data_out = data_q;
  assign ready    = ready_q;
  assign waiting  = waiting_q;

endmodule

// File: tb/tb_modulo_entrada.sv
// Directed bench for modulo_entrada: zero- and sign-extending instances share stimulus.
`timescale 1ns/1ps
module tb_modulo_entrada;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flag;
  logic [15:0] switches;
  logic        confirm;
  logic [31:0] data_zx, data_sx;
  logic        ready_zx, ready_sx, waiting_zx, waiting_sx;

  int checks = 0;
  int failures = 0;
  int ready_cnt = 0;

  always #5 clk = ~clk;

  modulo_entrada #(.SW_W(16), .SIGN_EXT(0), .DEBOUNCE_CYCLES(4)) u_zx (
    .clock(clk), .reset(rst_n), .flag(flag), .switches(switches), .confirm(confirm),
    .data_out(data_zx), .ready(ready_zx), .waiting(waiting_zx));

  modulo_entrada #(.SW_W(16), .SIGN_EXT(1), .DEBOUNCE_CYCLES(4)) u_sx (
    .clock(clk), .reset(rst_n), .flag(flag), .switches(switches), .confirm(confirm),
    .data_out(data_sx), .ready(ready_sx), .waiting(waiting_sx));

  always @(negedge clk) if (ready_zx) ready_cnt <= ready_cnt + 1;

  typedef struct {
    logic [15:0] sw;
    logic [31:0] exp_zx;
    logic [31:0] exp_sx;
  } vec_t;

  vec_t vecs[5];

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ticks until ready is seen (cycle index returned) or the bound expires (-1).
  task automatic wait_ready(input int bound, output int at);
    at = -1;
    for (int c = 1; c <= bound && at < 0; c++) begin
      tick();
      if (ready_zx) at = c;
    end
  endtask

  initial begin
    int at, base;

    vecs[0] = '{16'h8005, 32'h0000_8005, 32'hFFFF_8005};
    vecs[1] = '{16'h7FFF, 32'h0000_7FFF, 32'h0000_7FFF};
    vecs[2] = '{16'hFFFF, 32'h0000_FFFF, 32'hFFFF_FFFF};
    vecs[3] = '{16'h0000, 32'h0000_0000, 32'h0000_0000};
    vecs[4] = '{16'hA5C3, 32'h0000_A5C3, 32'hFFFF_A5C3};

    rst_n = 1'b0; flag = 1'b0; switches = '0; confirm = 1'b1;
    #2;
    chk("reset_data", data_zx, 32'h0);
    chk("reset_ready", {31'b0, ready_zx}, 32'h0);
    chk("reset_waiting", {31'b0, waiting_zx}, 32'h0);
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Press with no request is ignored.
    base = ready_cnt;
    confirm = 1'b0; tick(10);
    confirm = 1'b1; tick(10);
    chk("idle_press_ready", ready_cnt - base, 0);
    chk("idle_press_data", data_zx, 32'h0);

    // Request then abort without pressing.
    flag = 1'b1; tick();
    chk("abort_waiting_up", {31'b0, waiting_zx}, 32'h1);
    tick(9);
    flag = 1'b0; tick();
    chk("abort_waiting_down", {31'b0, waiting_zx}, 32'h0);
    tick(3);
    chk("abort_ready", ready_cnt - base, 0);
    chk("abort_data", data_zx, 32'h0);

    // Table: full request / clean press / release per vector.
    foreach (vecs[i]) begin
      switches = vecs[i].sw; tick(3);
      flag = 1'b1; tick();
      chk($sformatf("v%0d_waiting", i), {31'b0, waiting_zx}, 32'h1);
      base = ready_cnt;
      confirm = 1'b0;
      wait_ready(12, at);
      chk($sformatf("v%0d_latency", i), at, 7);
      chk($sformatf("v%0d_zx", i), data_zx, vecs[i].exp_zx);
      chk($sformatf("v%0d_sx", i), data_sx, vecs[i].exp_sx);
      flag = 1'b0; tick();
      chk($sformatf("v%0d_ready_low", i), {31'b0, ready_zx}, 32'h0);
      chk($sformatf("v%0d_waiting_low", i), {31'b0, waiting_zx}, 32'h0);
      tick(18);
      chk($sformatf("v%0d_one_pulse", i), ready_cnt - base, 1);
      confirm = 1'b1; tick(10);
    end

    // Bounce: toggles every 2 cycles, then held low.
    switches = 16'h0042; flag = 1'b1; tick(3);
    base = ready_cnt;
    for (int i = 0; i < 6; i++) begin
      confirm = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(2);
    end
    chk("bounce_no_ready", ready_cnt - base, 0);
    confirm = 1'b0;
    wait_ready(12, at);
    chk("bounce_latency_ok", (at >= 6 && at <= 8) ? 1 : 0, 1);
    chk("bounce_data", data_zx, 32'h0000_0042);
    flag = 1'b0; tick(15);
    chk("bounce_one_pulse", ready_cnt - base, 1);
    confirm = 1'b1; tick(10);

    // Held key across a second request.
    switches = 16'h1111; tick(3);
    flag = 1'b1; tick();
    confirm = 1'b0;
    wait_ready(12, at);
    chk("held_first_data", data_zx, 32'h0000_1111);
    flag = 1'b0; tick(3);
    base = ready_cnt;
    switches = 16'h2222; flag = 1'b1; tick(15);
    chk("held_no_capture", ready_cnt - base, 0);
    chk("held_not_waiting", {31'b0, waiting_zx}, 32'h0);
    confirm = 1'b1; tick(10);
    chk("held_rearmed", {31'b0, waiting_zx}, 32'h1);
    confirm = 1'b0;
    wait_ready(12, at);
    chk("held_second_latency", at, 7);
    chk("held_second_data", data_zx, 32'h0000_2222);
    flag = 1'b0; tick(5);
    confirm = 1'b1; tick(10);

    // Asynchronous reset while in WAIT_RELEASE.
    switches = 16'h1234; tick(3);
    flag = 1'b1; tick();
    confirm = 1'b0;
    wait_ready(12, at);
    chk("rst_pre_data", data_zx, 32'h0000_1234);
    flag = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async_data", data_zx, 32'h0);
    chk("rst_async_ready", {31'b0, ready_zx}, 32'h0);
    chk("rst_async_waiting", {31'b0, waiting_zx}, 32'h0);
    tick(3);
    #3 rst_n = 1'b1;
    base = ready_cnt;
    tick(12);
    flag = 1'b1; tick(12);
    chk("rst_held_no_event", ready_cnt - base, 0);
    chk("rst_held_waiting", {31'b0, waiting_zx}, 32'h1);
    chk("rst_held_data", data_zx, 32'h0);
    confirm = 1'b1; tick(8);
    confirm = 1'b0;
    wait_ready(12, at);
    chk("rst_repress_latency", at, 7);
    chk("rst_repress_data", data_zx, 32'h0000_1234);
    flag = 1'b0; tick(3);
    confirm = 1'b1; tick(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
